signal_ramp: RTL and testbench
==============================

SIGNAL_RAMP -- requirements
Module: signal_ramp

Interface
REQ-001 Port clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-002 Port reset  in  1  synchronous, active-high reset; SHALL act only on a rising clk edge.
REQ-003 Port ramp_enable  in  1  level; 1 requests output, 0 forces immediate return to IDLE.
REQ-004 Port ramp_down  in  1  level; 1 requests ramp-down from RAMP_UP/HOLD.
REQ-005 Port ramp_step  in  32  unsigned accumulator increment per cycle, sampled live every cycle.
REQ-006 Port comp_0..comp_3  in  16 each  signed waveform components.
REQ-007 Port offset  in  16  signed DC offset.
REQ-008 Port signal_out  out  19  signed scaled sum, the feed for the downstream limiter.
REQ-009 Port ramp_state  out  3  encoded FSM state: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, DONE=4.
REQ-010 Port ramp_done  out  1  high while the FSM is in DONE.

Function
REQ-011 Stage 1 SHALL register sum = comp_0+comp_1+comp_2+comp_3+offset, sign-extended to 19 bits, with no overflow possible (range -163840..163835).
REQ-012 Stage 1 SHALL register factor (17-bit unsigned) in the same cycle: IDLE/DONE=0; HOLD=65536; RAMP_UP/RAMP_DOWN={1'b0, acc[31:16]}.
REQ-013 Stage 2 SHALL register product = sum * factor (signed x unsigned, 36 bits).
REQ-014 Stage 3 SHALL register signal_out = product arithmetically shifted right by 16 (truncation toward minus infinity), 19 bits.
REQ-015 Input-to-output latency SHALL be exactly 3 cycles; factor changes SHALL appear at signal_out with the same 3-cycle alignment.
REQ-016 acc SHALL be a 32-bit unsigned ramp accumulator, cleared in IDLE.
REQ-017 IDLE: ramp_enable=1 -> RAMP_UP if ramp_step!=0, else HOLD.
REQ-018 RAMP_UP: acc+ramp_step >= 2^32 -> acc=0xFFFF_FFFF, go HOLD; otherwise acc+=ramp_step.
REQ-019 RAMP_UP/HOLD: ramp_down=1 -> RAMP_DOWN, keeping acc (HOLD loads acc=0xFFFF_FFFF); ramp_step=0 -> DONE directly.
REQ-020 RAMP_DOWN: acc < ramp_step -> acc=0, go DONE; otherwise acc-=ramp_step.
REQ-021 DONE SHALL persist until ramp_enable=0, then go IDLE; ramp_down is ignored in DONE and IDLE.
REQ-022 In any non-IDLE state, ramp_enable=0 SHALL take priority over every other condition and go IDLE next cycle with acc=0.
REQ-023 Simultaneous saturation and ramp_down in RAMP_UP SHALL go RAMP_DOWN with acc=0xFFFF_FFFF.
REQ-024 ramp_step changes mid-ramp SHALL take effect on the next accumulate without a state change.

Reset
REQ-025 reset=1 SHALL force state IDLE, acc=0, all pipeline registers 0, signal_out=0, ramp_state=0, ramp_done=0.
REQ-026 Reset mid-ramp SHALL abort without completing the ramp; the first non-reset cycle behaves as IDLE.

Configuration
REQ-027 Macro SIGNAL_RAMP_DOWN_EN defined: RAMP_DOWN and DONE behave per REQ-019..REQ-021.
REQ-028 SIGNAL_RAMP_DOWN_EN undefined: ramp_down SHALL be ignored, RAMP_DOWN/DONE logic absent, ramp_done tied 0; ramp exits only via ramp_enable=0.

Verification
REQ-029 comps=1000 each, offset=-500, ramp_enable=1, ramp_step=0 -> signal_out=3500 three cycles after HOLD entry.
REQ-030 sum=65536 (comp_0..comp_3=16384, offset=0), ramp_step=0x0100_0000 -> signal_out increments by 256 every cycle after the 3-cycle lag; HOLD after 256 steps, signal_out=65536.
REQ-031 All comps=-32768, offset=-32768, HOLD -> signal_out=-163840 with no wrap.
REQ-032 In HOLD, pulse ramp_down, ramp_step=0x1000_0000 -> 16 RAMP_DOWN cycles, then DONE, ramp_done=1, signal_out=0 three cycles later (SIGNAL_RAMP_DOWN_EN defined); same stimulus with macro undefined -> stays HOLD.
REQ-033 Mid RAMP_UP (acc=0x4000_0000), drop ramp_enable -> IDLE next cycle, signal_out=0 three cycles later; repeat with reset=1 instead -> identical outcome, all outputs 0.

Source files
------------

// File: rtl/signal_ramp.sv
// rtl/signal_ramp.sv - ramped gain applied to a summed waveform, three-stage pipeline
//
// Purpose: sums four signed waveform components plus a DC offset and scales the
// sum by a gain factor driven by a ramp FSM (IDLE, RAMP_UP, HOLD, RAMP_DOWN, DONE).
// The scaled result feeds the downstream limiter.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   ramp_enable    level request for output; 0 returns to IDLE
//   ramp_down      level request to ramp down (only with SIGNAL_RAMP_DOWN_EN)
//   ramp_step      32-bit unsigned accumulator increment, sampled every cycle
//   comp_0..comp_3 signed 16-bit waveform components
//   offset         signed 16-bit DC offset
//   signal_out     signed 19-bit scaled sum, 3-cycle latency
//   ramp_state     encoded FSM state
//   ramp_done      high while in DONE
//
// Configuration: define SIGNAL_RAMP_DOWN_EN to build the RAMP_DOWN/DONE path;
// otherwise ramp_down is ignored and ramp_done is tied low.

module signal_ramp (
    input  logic               clk,
    input  logic               reset,
    input  logic               ramp_enable,
    input  logic               ramp_down,
    input  logic [31:0]        ramp_step,
    input  logic signed [15:0] comp_0,
    input  logic signed [15:0] comp_1,
    input  logic signed [15:0] comp_2,
    input  logic signed [15:0] comp_3,
    input  logic signed [15:0] offset,
    output logic signed [18:0] signal_out,
    output logic [2:0]         ramp_state,
    output logic               ramp_done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [31:0] ACC_FULL = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [32:0] acc_sum;
    logic        acc_carry;
    logic [16:0] factor_c;

    logic signed [18:0] sum_c;
    logic signed [18:0] sum_s1;
    logic [16:0]        factor_s1;
    logic signed [36:0] prod_full;
    logic signed [35:0] prod_s2;

`ifndef SIGNAL_RAMP_DOWN_EN
    logic unused_ramp_down;
    assign unused_ramp_down = ramp_down;
`endif

    // One extra bit catches the wrap past 2^32 that triggers saturation.
    assign acc_sum   = {1'b0, acc_q} + {1'b0, ramp_step};
    assign acc_carry = acc_sum[32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                if (ramp_enable)
                    state_d = (ramp_step != 32'd0) ? ST_RAMP_UP : ST_HOLD;
            end
            ST_RAMP_UP: begin
                if (!ramp_enable) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end
`ifdef SIGNAL_RAMP_DOWN_EN
                else if (ramp_down) begin
                    // A saturating step in the same cycle still lands at full scale.
                    state_d = ST_RAMP_DOWN;
                    acc_d   = acc_carry ? ACC_FULL : acc_q;
                end else if (ramp_step == 32'd0) begin
                    state_d = ST_DONE;
                end
`endif
                else if (acc_carry) begin
                    state_d = ST_HOLD;
                    acc_d   = ACC_FULL;
                end else begin
                    acc_d = acc_sum[31:0];
                end
            end
            ST_HOLD: begin
                if (!ramp_enable) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end
`ifdef SIGNAL_RAMP_DOWN_EN
                else if (ramp_down) begin
                    // HOLD may be entered directly from IDLE with acc=0.
                    state_d = ST_RAMP_DOWN;
                    acc_d   = ACC_FULL;
                end else if (ramp_step == 32'd0) begin
                    state_d = ST_DONE;
                end
`endif
            end
`ifdef SIGNAL_RAMP_DOWN_EN
            ST_RAMP_DOWN: begin
                if (!ramp_enable) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end else if (acc_q < ramp_step) begin
                    state_d = ST_DONE;
                    acc_d   = '0;
                end else begin
                    acc_d = acc_q - ramp_step;
                end
            end
            ST_DONE: begin
                if (!ramp_enable) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
            end
        endcase
    end

    always_comb begin
        factor_c = '0;
        case (state_q)
            ST_RAMP_UP, ST_RAMP_DOWN: factor_c = {1'b0, acc_q[31:16]};
            ST_HOLD:                  factor_c = 17'h1_0000;
            default:                  factor_c = '0;
        endcase
    end

    assign sum_c = {{3{comp_0[15]}}, comp_0} + {{3{comp_1[15]}}, comp_1}
                 + {{3{comp_2[15]}}, comp_2} + {{3{comp_3[15]}}, comp_3}
                 + {{3{offset[15]}}, offset};

    // Factor is zero-extended so the multiply stays signed x unsigned.
    assign prod_full = sum_s1 * $signed({1'b0, factor_s1});

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_s1     <= '0;
            factor_s1  <= '0;
            prod_s2    <= '0;
            signal_out <= '0;
        end else begin
            sum_s1     <= sum_c;
            factor_s1  <= factor_c;
            prod_s2    <= prod_full[35:0];
            // Taking bits [34:16] is an arithmetic shift by 16 (floor); the
            // factor never exceeds 1.0 so the result always fits 19 bits.
            signal_out <= prod_s2[34:16];
        end
    end

    assign ramp_state = state_q;

`ifdef SIGNAL_RAMP_DOWN_EN
    assign ramp_done = (state_q == ST_DONE);
`else
    assign ramp_done = 1'b0;
`endif

endmodule

// File: tb/tb_signal_ramp.sv
// tb/tb_signal_ramp.sv - self-checking bench for signal_ramp

module tb_signal_ramp;

    logic               clk = 1'b0;
    logic               reset;
    logic               ramp_enable;
    logic               ramp_down;
    logic [31:0]        ramp_step;
    logic signed [15:0] comp_0, comp_1, comp_2, comp_3, offset;
    logic signed [18:0] signal_out;
    logic [2:0]         ramp_state;
    logic               ramp_done;

    int n_vec = 0;
    int n_err = 0;

    int      m_state;
    longint  m_acc;
    longint  exp_q[$];

    signal_ramp dut (
        .clk         (clk),
        .reset       (reset),
        .ramp_enable (ramp_enable),
        .ramp_down   (ramp_down),
        .ramp_step   (ramp_step),
        .comp_0      (comp_0),
        .comp_1      (comp_1),
        .comp_2      (comp_2),
        .comp_3      (comp_3),
        .offset      (offset),
        .signal_out  (signal_out),
        .ramp_state  (ramp_state),
        .ramp_done   (ramp_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint model_factor();
        case (m_state)
            1, 3:    return m_acc >> 16;
            2:       return 65536;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        longint nsum;
        bit     carry;
        nsum  = m_acc + longint'(ramp_step);
        carry = (nsum > 64'sh0_FFFF_FFFF);
        case (m_state)
            0: begin
                m_acc = 0;
                if (ramp_enable) m_state = (ramp_step != 0) ? 1 : 2;
            end
            1: begin
                if (!ramp_enable) begin m_state = 0; m_acc = 0; end
`ifdef SIGNAL_RAMP_DOWN_EN
                else if (ramp_down) begin m_state = 3; if (carry) m_acc = 64'hFFFF_FFFF; end
                else if (ramp_step == 0) m_state = 4;
`endif
                else if (carry) begin m_state = 2; m_acc = 64'hFFFF_FFFF; end
                else m_acc = nsum;
            end
            2: begin
                if (!ramp_enable) begin m_state = 0; m_acc = 0; end
`ifdef SIGNAL_RAMP_DOWN_EN
                else if (ramp_down) begin m_state = 3; m_acc = 64'hFFFF_FFFF; end
                else if (ramp_step == 0) m_state = 4;
`endif
            end
            3: begin
                if (!ramp_enable) begin m_state = 0; m_acc = 0; end
                else if (m_acc < longint'(ramp_step)) begin m_state = 4; m_acc = 0; end
                else m_acc = m_acc - longint'(ramp_step);
            end
            4: if (!ramp_enable) begin m_state = 0; m_acc = 0; end
            default: begin m_state = 0; m_acc = 0; end
        endcase
    endtask

    // One clock: expected output for the current inputs is queued, the model
    // advances, and after the edge the oldest queued value is compared.
    task automatic tick();
        longint s, e;
        bit     was_reset;
        s = longint'(comp_0) + longint'(comp_1) + longint'(comp_2)
          + longint'(comp_3) + longint'(offset);
        e = (s * model_factor()) >>> 16;
        was_reset = reset;
        if (reset) begin
            m_state = 0;
            m_acc   = 0;
        end else begin
            model_step();
        end
        @(posedge clk);
        #1;
        if (was_reset) begin
            exp_q.delete();
            repeat (3) exp_q.push_back(0);
        end else begin
            exp_q.push_back(e);
        end
        if (exp_q.size() >= 3) check("signal_out", longint'(signal_out), exp_q.pop_front());
        check("ramp_state", longint'(ramp_state), longint'(m_state));
        check("ramp_done", longint'(ramp_done), longint'(m_state == 4));
    endtask

    task automatic set_comps(input int c, input int o);
        comp_0 = 16'(c); comp_1 = 16'(c); comp_2 = 16'(c); comp_3 = 16'(c);
        offset = 16'(o);
    endtask

    task automatic go_idle();
        ramp_enable = 1'b0;
        ramp_down   = 1'b0;
        tick();
    endtask

    initial begin
        int cnt;
        reset = 1'b1; ramp_enable = 1'b0; ramp_down = 1'b0; ramp_step = '0;
        set_comps(0, 0);
        m_state = 0; m_acc = 0;
        tick();
        tick();
        check("reset_out", longint'(signal_out), 0);
        check("reset_state", longint'(ramp_state), 0);
        reset = 1'b0;
        tick();

        // Constant-gain hold from IDLE with zero step.
        set_comps(1000, -500);
        ramp_enable = 1'b1; ramp_step = 32'd0;
        tick();
        check("hold_entry", longint'(ramp_state), 2);
        repeat (3) tick();
        check("hold_out_3500", longint'(signal_out), 3500);
        go_idle();
        repeat (3) tick();
        check("idle_out", longint'(signal_out), 0);

        // Most negative sum passes through without wrap.
        set_comps(-32768, -32768);
        ramp_enable = 1'b1; ramp_step = 32'd0;
        tick();
        repeat (3) tick();
        check("neg_full_scale", longint'(signal_out), -163840);
        go_idle();

        // Linear ramp to full scale: 256 accumulate cycles, then HOLD.
        set_comps(16384, 0);
        ramp_enable = 1'b1; ramp_step = 32'h0100_0000;
        cnt = 0;
        for (int i = 0; i < 400 && ramp_state != 3'd2; i++) begin
            tick();
            if (ramp_state == 3'd1) cnt++;
        end
        check("ramp_hold_reached", longint'(ramp_state), 2);
        check("ramp_up_cycles", longint'(cnt), 256);
        repeat (3) tick();
        check("ramp_full_out", longint'(signal_out), 65536);

        // Hold, then pulse ramp_down with a 1/16 step.
        ramp_step = 32'h1000_0000;
        ramp_down = 1'b1;
        tick();
        ramp_down = 1'b0;
`ifdef SIGNAL_RAMP_DOWN_EN
        cnt = (ramp_state == 3'd3) ? 1 : 0;
        for (int i = 0; i < 30 && ramp_state != 3'd4; i++) begin
            tick();
            if (ramp_state == 3'd3) cnt++;
        end
        check("down_cycles", longint'(cnt), 16);
        check("down_done_state", longint'(ramp_state), 4);
        check("down_done_flag", longint'(ramp_done), 1);
        repeat (3) tick();
        check("down_done_out", longint'(signal_out), 0);
`else
        repeat (20) tick();
        check("down_ignored_state", longint'(ramp_state), 2);
        check("down_ignored_flag", longint'(ramp_done), 0);
`endif
        go_idle();

        // Abort mid-ramp by dropping ramp_enable.
        ramp_enable = 1'b1; ramp_step = 32'h0400_0000;
        for (int i = 0; i < 100 && !(m_state == 1 && m_acc == 64'h4000_0000); i++) tick();
        check("abort_acc_reached", m_acc, 64'h4000_0000);
        ramp_enable = 1'b0;
        tick();
        check("abort_en_state", longint'(ramp_state), 0);
        repeat (3) tick();
        check("abort_en_out", longint'(signal_out), 0);

        // Same abort by reset.
        ramp_enable = 1'b1;
        for (int i = 0; i < 100 && !(m_state == 1 && m_acc == 64'h4000_0000); i++) tick();
        check("abort_rst_acc_reached", m_acc, 64'h4000_0000);
        reset = 1'b1;
        tick();
        check("abort_rst_state", longint'(ramp_state), 0);
        check("abort_rst_out", longint'(signal_out), 0);
        check("abort_rst_done", longint'(ramp_done), 0);
        reset = 1'b0;
        go_idle();

        // Random traffic with live step changes, ramp_down pulses and resets.
        for (int i = 0; i < 1500; i++) begin
            ramp_enable = ($urandom_range(0, 39) != 0);
            ramp_down   = ($urandom_range(0, 15) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 7))
                0:       ramp_step = 32'd0;
                1:       ramp_step = $urandom;
                default: ramp_step = $urandom_range(1, 32'h0400_0000);
            endcase
            comp_0 = 16'($urandom); comp_1 = 16'($urandom);
            comp_2 = 16'($urandom); comp_3 = 16'($urandom);
            offset = 16'($urandom);
            tick();
        end
        reset = 1'b0;
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
